// File: rtl/aes_chip_link_pkg.sv
// aes_link_pkg: shared constants, TX state type and helpers for the AES chip link.
package aes_link_pkg;

  localparam int LINK_BYTES = 16;
  localparam int LINK_W     = 9;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_LOAD   = 3'd1,
    TX_SETUP  = 3'd2,
    TX_TOGGLE = 3'd3,
    TX_HOLD   = 3'd4
  } tx_state_t;

  // Largest of three sizes; used to size the shared wait/idle counters.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/aes_chip_link_if.sv
// aes_chip_link_if: core-side block handshakes of the AES chip link.
// master = link endpoint (delivers RX blocks, accepts results), slave = AES core.
interface aes_chip_link_if;
  import aes_link_pkg::*;

  logic [LINK_BYTES*8-1:0] blk_data;
  logic                    blk_valid;
  logic                    blk_ready;
  logic [LINK_BYTES*8-1:0] res_data;
  logic                    res_valid;
  logic                    res_ready;

  modport master (
    output blk_data, blk_valid, res_ready,
    input  blk_ready, res_data, res_valid
  );

  modport slave (
    input  blk_data, blk_valid, res_ready,
    output blk_ready, res_data, res_valid
  );
endinterface

// File: rtl/aes_chip_link_toggle_sync.sv
// link_toggle_sync: brings the asynchronous shakehand toggle into the clk domain
// (2-flop synchroniser + edge flop) and carries the byte through two flops in step,
// so byte_data is the value that was stable around the detected toggle.
module link_toggle_sync
  import aes_link_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [LINK_W-1:0] link_in,
  output logic              byte_vld,
  output logic [7:0]        byte_data
);

  logic       tgl_meta_r;
  logic       tgl_sync_r;
  logic       tgl_last_r;
  logic [7:0] dat_meta_r;
  logic [7:0] dat_sync_r;

  // Synchronise toggle and data together; keep previous synced level for edge detect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tgl_meta_r <= 1'b0;
      tgl_sync_r <= 1'b0;
      tgl_last_r <= 1'b0;
      dat_meta_r <= 8'h00;
      dat_sync_r <= 8'h00;
    end else begin
      tgl_meta_r <= link_in[LINK_W-1];
      tgl_sync_r <= tgl_meta_r;
      tgl_last_r <= tgl_sync_r;
      dat_meta_r <= link_in[7:0];
      dat_sync_r <= dat_meta_r;
    end
  end

  // Any transition (rise or fall) of the synced toggle marks one new byte.
  assign byte_vld  = tgl_sync_r ^ tgl_last_r;
  assign byte_data = dat_sync_r;

endmodule

// File: rtl/aes_chip_link.sv
// aes_chip_link: chip-side endpoint of the byte-serial AES test link.
// RX deserialises 16 toggle-handshake bytes into a 128-bit block for the core
// (holding register + shift register); TX serialises core results onto link_out
// with SETUP_CYC data setup and HOLD_CYC hold around each toggle.
// Optional macro LINK_TIMEOUT_EN: abort a partial RX block after TIMEOUT_CYC idle clocks.
module aes_chip_link
  import aes_link_pkg::*;
#(
  parameter int SETUP_CYC   = 4,
  parameter int HOLD_CYC    = 8,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [LINK_W-1:0] link_in,
  output logic [LINK_W-1:0] link_out,
  aes_chip_link_if.master   core,
  output logic              rx_overflow,
  output logic              rx_timeout
);

  localparam int                BLK_W      = LINK_BYTES * 8;
  localparam int                WAIT_W     = $clog2(max3(SETUP_CYC, HOLD_CYC, TIMEOUT_CYC) + 1);
  localparam logic [3:0]        LAST_IDX   = 4'(LINK_BYTES - 1);
  localparam logic [WAIT_W-1:0] SETUP_LAST = WAIT_W'(SETUP_CYC - 1);
  localparam logic [WAIT_W-1:0] HOLD_LAST  = WAIT_W'(HOLD_CYC - 1);

  // ---------------- RX ----------------
  logic             rx_vld_s;
  logic [7:0]       rx_byte_s;
  logic [BLK_W-1:0] rx_shift_next_s;
  logic             rx_abort_s;
  logic [BLK_W-1:0] rx_shift_r;
  logic [3:0]       rx_cnt_r;
  logic [BLK_W-1:0] blk_data_r;
  logic             blk_valid_r;
  logic             rx_overflow_r;

  link_toggle_sync u_sync (
    .clk       (clk),
    .rst       (rst),
    .link_in   (link_in),
    .byte_vld  (rx_vld_s),
    .byte_data (rx_byte_s)
  );

  assign rx_shift_next_s = {rx_shift_r[BLK_W-9:0], rx_byte_s};

  // Shift bytes in, hand complete blocks to the holding register or flag overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_shift_r    <= {BLK_W{1'b0}};
      rx_cnt_r      <= 4'd0;
      blk_data_r    <= {BLK_W{1'b0}};
      blk_valid_r   <= 1'b0;
      rx_overflow_r <= 1'b0;
    end else begin
      if (rx_vld_s) begin
        rx_shift_r <= rx_shift_next_s;
        rx_cnt_r   <= rx_cnt_r + 4'd1;
      end else if (rx_abort_s) begin
        rx_cnt_r   <= 4'd0;
      end
      if (rx_vld_s && (rx_cnt_r == LAST_IDX)) begin
        if (!blk_valid_r || core.blk_ready) begin
          blk_data_r  <= rx_shift_next_s;
          blk_valid_r <= 1'b1;
        end else begin
          rx_overflow_r <= 1'b1;
        end
      end else if (blk_valid_r && core.blk_ready) begin
        blk_valid_r <= 1'b0;
      end
    end
  end

`ifdef LINK_TIMEOUT_EN
  logic [WAIT_W-1:0] idle_cnt_r;
  logic              rx_timeout_r;

  assign rx_abort_s = !rx_vld_s && (rx_cnt_r != 4'd0) &&
                      (idle_cnt_r == WAIT_W'(TIMEOUT_CYC - 1));

  // Idle counter for a partial block; restarts on every byte, saturates otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_cnt_r   <= {WAIT_W{1'b0}};
      rx_timeout_r <= 1'b0;
    end else begin
      rx_timeout_r <= rx_abort_s;
      if (rx_vld_s || (rx_cnt_r == 4'd0) || rx_abort_s) begin
        idle_cnt_r <= {WAIT_W{1'b0}};
      end else if (idle_cnt_r != {WAIT_W{1'b1}}) begin
        idle_cnt_r <= idle_cnt_r + 1'b1;
      end
    end
  end

  assign rx_timeout = rx_timeout_r;
`else
  assign rx_abort_s = 1'b0;
  assign rx_timeout = 1'b0;
`endif

  assign core.blk_data  = blk_data_r;
  assign core.blk_valid = blk_valid_r;
  assign rx_overflow    = rx_overflow_r;

  // ---------------- TX ----------------
  tx_state_t         state_r, state_next_s;
  logic [BLK_W-1:0]  tx_shift_r, tx_shift_next_s;
  logic [3:0]        idx_r, idx_next_s;
  logic [WAIT_W-1:0] wait_r, wait_next_s;
  logic [7:0]        out_byte_r, out_byte_next_s;
  logic              out_tgl_r, out_tgl_next_s;
  logic              res_ready_r;

  // TX state register and datapath registers; res_ready is high exactly while in IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= TX_IDLE;
      tx_shift_r  <= {BLK_W{1'b0}};
      idx_r       <= 4'd0;
      wait_r      <= {WAIT_W{1'b0}};
      out_byte_r  <= 8'h00;
      out_tgl_r   <= 1'b0;
      res_ready_r <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      tx_shift_r  <= tx_shift_next_s;
      idx_r       <= idx_next_s;
      wait_r      <= wait_next_s;
      out_byte_r  <= out_byte_next_s;
      out_tgl_r   <= out_tgl_next_s;
      res_ready_r <= (state_next_s == TX_IDLE);
    end
  end

  // TX next-state and datapath: byte out, wait setup, toggle, wait hold, repeat 16x.
  always_comb begin
    state_next_s    = state_r;
    tx_shift_next_s = tx_shift_r;
    idx_next_s      = idx_r;
    wait_next_s     = wait_r;
    out_byte_next_s = out_byte_r;
    out_tgl_next_s  = out_tgl_r;
    case (state_r)
      TX_IDLE: begin
        if (core.res_valid && res_ready_r) begin
          tx_shift_next_s = core.res_data;
          idx_next_s      = 4'd0;
          state_next_s    = TX_LOAD;
        end else begin
          state_next_s    = TX_IDLE;
        end
      end
      TX_LOAD: begin
        out_byte_next_s = tx_shift_r[BLK_W-1 -: 8];
        wait_next_s     = {WAIT_W{1'b0}};
        state_next_s    = TX_SETUP;
      end
      TX_SETUP: begin
        if (wait_r >= SETUP_LAST) begin
          wait_next_s  = {WAIT_W{1'b0}};
          state_next_s = TX_TOGGLE;
        end else begin
          wait_next_s  = wait_r + 1'b1;
        end
      end
      TX_TOGGLE: begin
        out_tgl_next_s = ~out_tgl_r;
        wait_next_s    = {WAIT_W{1'b0}};
        state_next_s   = TX_HOLD;
      end
      TX_HOLD: begin
        if (wait_r >= HOLD_LAST) begin
          wait_next_s = {WAIT_W{1'b0}};
          if (idx_r == LAST_IDX) begin
            state_next_s = TX_IDLE;
          end else begin
            idx_next_s      = idx_r + 4'd1;
            tx_shift_next_s = tx_shift_r << 8;
            out_byte_next_s = tx_shift_r[BLK_W-9 -: 8];
            state_next_s    = TX_SETUP;
          end
        end else begin
          wait_next_s = wait_r + 1'b1;
        end
      end
      default: begin
        wait_next_s  = {WAIT_W{1'b0}};
        state_next_s = TX_IDLE;
      end
    endcase
  end

  assign link_out       = {out_tgl_r, out_byte_r};
  assign core.res_ready = res_ready_r;

endmodule
